otter_mcu_ctrl: RTL and testbench
=================================

Name: otter_mcu_ctrl

Overview:
Multicycle control FSM for the OTTER RV32I core. It sequences the PC register, instruction memory port 1, data memory port 2, register file and CSR file. Each instruction runs FETCH -> EXEC [-> WRITEBACK] with a ready-handshake wait on data memory, a bounded timeout, and interrupt entry between instructions. It drives the same PC_WRITE / MEM_READ1 controls used by the PC + instruction-memory fetch path.

Parameters:
TIMEOUT, 16, max cycles waiting for MEM_READY2 before a bus-error abort (>=2)
CW, 5, width of wait counter; must satisfy 2**CW > TIMEOUT

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous reset, active-low (0 = reset)
OPCODE  in  7  instruction[6:0], valid from EXEC onward
FUNC3  in  3  instruction[14:12]
INTR  in  1  level interrupt request (synchronised upstream)
INT_EN  in  1  mstatus.MIE
MEM_READY2  in  1  data memory completes current port-2 access this cycle
PC_WRITE  out  1  load PC this cycle
MEM_READ1  out  1  instruction fetch strobe
MEM_READ2  out  1  data read strobe
MEM_WE2  out  1  data write strobe
REG_WRITE  out  1  register file write enable
CSR_WE  out  1  CSR write enable
INT_TAKEN  out  1  one-cycle pulse: PC loads mtvec, mepc/mcause update
MRET_EXEC  out  1  one-cycle pulse on MRET
ILLEGAL  out  1  one-cycle pulse on unknown opcode
BUS_ERR  out  1  one-cycle pulse on data-memory timeout
STATE  out  2  current state for debug (FETCH=0, EXEC=1, WB=2, INTR=3)

Behaviour:
- Reset (RESET=0, async): state=FETCH, wait counter=0, all outputs 0 except STATE=0. Outputs remain registered-state decoded (Moore), except that EXEC/WB decode uses OPCODE/MEM_READY2 combinationally.
- First cycle after reset release: FETCH.
- FETCH: MEM_READ1=1; -> EXEC unconditionally (1-cycle synchronous instruction read).
- EXEC, decode OPCODE:
  - OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: REG_WRITE=1, PC_WRITE=1.
  - BRANCH 1100011: PC_WRITE=1 only.
  - SYSTEM 1110011, FUNC3!=0 (CSRRW etc.): CSR_WE=1, REG_WRITE=1, PC_WRITE=1.
  - SYSTEM, FUNC3==0 (MRET): MRET_EXEC=1, PC_WRITE=1.
  - LOAD 0000011: MEM_READ2=1, no PC_WRITE; -> WB, counter cleared.
  - STORE 0100011: MEM_WE2=1 held every cycle; stay in EXEC, counter++ until MEM_READY2=1. On that cycle PC_WRITE=1, then retire.
  - Any other opcode: ILLEGAL=1, PC_WRITE=1, no writes.
- WB (loads only): MEM_READ2 held; counter++ each cycle MEM_READY2=0. When MEM_READY2=1: REG_WRITE=1, PC_WRITE=1, retire.
- Timeout: if the counter reaches TIMEOUT while waiting (STORE in EXEC or WB) and MEM_READY2=0 that cycle: BUS_ERR=1, PC_WRITE=1, REG_WRITE=0, MEM_WE2 deasserted; retire. MEM_READY2=1 on the same cycle as the counter hitting TIMEOUT counts as success.
- Retire: next state is INTR if INTR & INT_EN, else FETCH. These inputs are sampled only on the retiring cycle. An interrupt is never taken mid-instruction.
- INTR: INT_TAKEN=1, PC_WRITE=1; -> FETCH. INTR still high afterward does not retake until the next retire (the CSR file clears MIE).
- Minimum instruction latency: 2 cycles (FETCH, EXEC). A load takes >=3 cycles.
- Async reset mid-load/store: strobes drop immediately with RESET, and no write or PC update occurs.

Decomposition:
- Package otter_ctrl_pkg: state enum (FETCH, EXEC, WB, INTR; 2-bit) and opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM).
- Sub-module otter_wait_timer: CW-bit counter with clear/enable inputs and an expired output (count==TIMEOUT); instantiated once.

Test Plan:
- Reset release, OPCODE=0110011 -> STATE 0,1,0,1; MEM_READ1 in cycle 0; REG_WRITE and PC_WRITE exactly in cycle 1.
- LOAD with MEM_READY2 high on the 3rd WB cycle -> MEM_READ2 held 4 cycles (EXEC + 3 WB); single REG_WRITE+PC_WRITE pulse on the 3rd WB cycle; total 5 cycles.
- STORE, MEM_READY2 never high, TIMEOUT=4 -> MEM_WE2 high 4 cycles, then BUS_ERR and PC_WRITE pulse with no REG_WRITE; next state FETCH.
- OP_IMM with INTR=1, INT_EN=1 -> EXEC, then INTR state (INT_TAKEN=1, PC_WRITE=1), then FETCH. Same stimulus with INT_EN=0 -> no INT_TAKEN.
- OPCODE=1111111 -> ILLEGAL and PC_WRITE pulse, REG_WRITE=0. SYSTEM FUNC3=0 -> MRET_EXEC pulse. FUNC3=001 -> CSR_WE and REG_WRITE.
- RESET low for 1 cycle in the 2nd WB cycle of a load -> MEM_READ2 drops asynchronously, no REG_WRITE; restart in FETCH with the counter at 0.

Source files
------------

// File: rtl/otter_ctrl_pkg.sv
// Shared types and opcode constants for the OTTER multicycle control path.
package otter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Single-cycle instructions that write rd and advance the PC.
  function automatic logic is_reg_wb(input logic [6:0] opc);
    return (opc == OPC_OP)  || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL)  || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/otter_wait_timer.sv
// Wait-cycle counter for data-memory handshakes; flags when TIMEOUT is reached.
module otter_wait_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/otter_mcu_ctrl.sv
// Multicycle control FSM for the OTTER RV32I core: fetch, execute, load
// writeback, memory-wait timeout and interrupt entry between instructions.
module otter_mcu_ctrl
  import otter_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNC3,
  input  logic       INTR,
  input  logic       INT_EN,
  input  logic       MEM_READY2,
  output logic       PC_WRITE,
  output logic       MEM_READ1,
  output logic       MEM_READ2,
  output logic       MEM_WE2,
  output logic       REG_WRITE,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC,
  output logic       ILLEGAL,
  output logic       BUS_ERR,
  output logic [1:0] STATE
);

  state_e state_q;
  state_e state_d;
  logic   tmr_clr;
  logic   tmr_en;
  logic   tmr_expired;
  logic   retire;

  otter_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_wait_timer (
    .clk    (CLK),
    .rst_n  (RESET),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    PC_WRITE  = 1'b0;
    MEM_READ1 = 1'b0;
    MEM_READ2 = 1'b0;
    MEM_WE2   = 1'b0;
    REG_WRITE = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    ILLEGAL   = 1'b0;
    BUS_ERR   = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    retire    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        MEM_READ1 = 1'b1;
        tmr_clr   = 1'b1;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        if (is_reg_wb(OPCODE)) begin
          REG_WRITE = 1'b1;
          PC_WRITE  = 1'b1;
          retire    = 1'b1;
        end else begin
          case (OPCODE)
            OPC_BRANCH: begin
              PC_WRITE = 1'b1;
              retire   = 1'b1;
            end
            OPC_SYSTEM: begin
              if (FUNC3 != 3'b000) begin
                CSR_WE    = 1'b1;
                REG_WRITE = 1'b1;
              end else begin
                MRET_EXEC = 1'b1;
              end
              PC_WRITE = 1'b1;
              retire   = 1'b1;
            end
            OPC_LOAD: begin
              MEM_READ2 = 1'b1;
              tmr_clr   = 1'b1;
              state_d   = ST_WB;
            end
            OPC_STORE: begin
              // Ready wins over expiry on the same cycle.
              if (MEM_READY2) begin
                MEM_WE2  = 1'b1;
                PC_WRITE = 1'b1;
                retire   = 1'b1;
              end else if (tmr_expired) begin
                BUS_ERR  = 1'b1;
                PC_WRITE = 1'b1;
                retire   = 1'b1;
              end else begin
                MEM_WE2 = 1'b1;
                tmr_en  = 1'b1;
              end
            end
            default: begin
              ILLEGAL  = 1'b1;
              PC_WRITE = 1'b1;
              retire   = 1'b1;
            end
          endcase
        end
      end

      ST_WB: begin
        MEM_READ2 = 1'b1;
        if (MEM_READY2) begin
          REG_WRITE = 1'b1;
          PC_WRITE  = 1'b1;
          retire    = 1'b1;
        end else if (tmr_expired) begin
          BUS_ERR  = 1'b1;
          PC_WRITE = 1'b1;
          retire   = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_INTR: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        tmr_clr   = 1'b1;
        state_d   = ST_FETCH;
      end
    endcase

    if (retire) begin
      tmr_clr = 1'b1;
      state_d = (INTR && INT_EN) ? ST_INTR : ST_FETCH;
    end

    // Strobes must fall together with the asynchronous reset, not at the next edge.
    if (!RESET) begin
      PC_WRITE  = 1'b0;
      MEM_READ1 = 1'b0;
      MEM_READ2 = 1'b0;
      MEM_WE2   = 1'b0;
      REG_WRITE = 1'b0;
      CSR_WE    = 1'b0;
      INT_TAKEN = 1'b0;
      MRET_EXEC = 1'b0;
      ILLEGAL   = 1'b0;
      BUS_ERR   = 1'b0;
      state_d   = ST_FETCH;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_otter_mcu_ctrl.sv
// Scoreboard bench for otter_mcu_ctrl: per-cycle expected control vectors are
// derived from instruction-level rules and checked by an independent monitor.
module tb_otter_mcu_ctrl;

  localparam int unsigned TO = 4;

  localparam logic [6:0] C_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_IMM = 7'b0010011;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_SYSTEM = 7'b1110011;

  // Vector layout: {STATE[1:0], PC_WRITE, MEM_READ1, MEM_READ2, MEM_WE2,
  //                 REG_WRITE, CSR_WE, INT_TAKEN, MRET_EXEC, ILLEGAL, BUS_ERR}
  typedef logic [11:0] exp_t;
  localparam logic [9:0] F_NONE = 10'b0000000000;
  localparam logic [9:0] F_PCW  = 10'b1000000000;
  localparam logic [9:0] F_MR1  = 10'b0100000000;
  localparam logic [9:0] F_MR2  = 10'b0010000000;
  localparam logic [9:0] F_WE2  = 10'b0001000000;
  localparam logic [9:0] F_RW   = 10'b0000100000;
  localparam logic [9:0] F_CSR  = 10'b0000010000;
  localparam logic [9:0] F_IT   = 10'b0000001000;
  localparam logic [9:0] F_MRET = 10'b0000000100;
  localparam logic [9:0] F_ILL  = 10'b0000000010;
  localparam logic [9:0] F_BERR = 10'b0000000001;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic       INTR;
  logic       INT_EN;
  logic       MEM_READY2;
  logic       PC_WRITE, MEM_READ1, MEM_READ2, MEM_WE2, REG_WRITE, CSR_WE;
  logic       INT_TAKEN, MRET_EXEC, ILLEGAL, BUS_ERR;
  logic [1:0] STATE;
  exp_t       act;

  int checks   = 0;
  int failures = 0;

  exp_t  sb_q[$];
  string tag_q[$];

  always #5 CLK = ~CLK;

  otter_mcu_ctrl #(
    .TIMEOUT(TO),
    .CW     (3)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .OPCODE    (OPCODE),
    .FUNC3     (FUNC3),
    .INTR      (INTR),
    .INT_EN    (INT_EN),
    .MEM_READY2(MEM_READY2),
    .PC_WRITE  (PC_WRITE),
    .MEM_READ1 (MEM_READ1),
    .MEM_READ2 (MEM_READ2),
    .MEM_WE2   (MEM_WE2),
    .REG_WRITE (REG_WRITE),
    .CSR_WE    (CSR_WE),
    .INT_TAKEN (INT_TAKEN),
    .MRET_EXEC (MRET_EXEC),
    .ILLEGAL   (ILLEGAL),
    .BUS_ERR   (BUS_ERR),
    .STATE     (STATE)
  );

  assign act = {STATE, PC_WRITE, MEM_READ1, MEM_READ2, MEM_WE2, REG_WRITE,
                CSR_WE, INT_TAKEN, MRET_EXEC, ILLEGAL, BUS_ERR};

  function automatic exp_t mk(input logic [1:0] st, input logic [9:0] f);
    return {st, f};
  endfunction

  // Architectural effect of a single-cycle (non-memory) instruction.
  function automatic logic [9:0] exec_flags(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      C_OP, C_OP_IMM, C_LUI, C_AUIPC, C_JAL, C_JALR: return F_RW | F_PCW;
      C_BRANCH: return F_PCW;
      C_SYSTEM: return (f3 != 3'b000) ? (F_CSR | F_RW | F_PCW) : (F_MRET | F_PCW);
      default:  return F_ILL | F_PCW;
    endcase
  endfunction

  // Monitor: compares one scoreboard entry per cycle, mid-cycle.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %b expected %b", t, act, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input exp_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, act, e);
    end
  endtask

  // Called at cycle start (#1 after posedge); returns at the next cycle start.
  task automatic cyc(input logic [6:0] opc, input logic [2:0] f3, input logic rdy,
                     input logic ir, input logic ie, input exp_t e, input string tag);
    OPCODE     = opc;
    FUNC3      = f3;
    MEM_READY2 = rdy;
    INTR       = ir;
    INT_EN     = ie;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
  endtask

  task automatic rnd_cyc(input exp_t e, input string tag);
    cyc(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), e, tag);
  endtask

  // rdy_k: index of the wait cycle where MEM_READY2 rises (> TO means never).
  // imode: 0 random INTR/INT_EN at retire, 1 forced 1/1, 2 forced 1/0.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3,
                           input int rdy_k, input int imode, input string tag);
    logic ir, ie;
    bit   done;
    ir = 1'($urandom);
    ie = 1'($urandom);
    if (imode == 1) begin ir = 1'b1; ie = 1'b1; end
    if (imode == 2) begin ir = 1'b1; ie = 1'b0; end

    rnd_cyc(mk(2'd0, F_MR1), {tag, "/fetch"});
    if (opc == C_LOAD) begin
      cyc(opc, f3, 1'($urandom), 1'($urandom), 1'($urandom), mk(2'd1, F_MR2), {tag, "/exec"});
      done = 1'b0;
      for (int w = 0; w <= int'(TO) && !done; w++) begin
        if (w == rdy_k) begin
          cyc(opc, f3, 1'b1, ir, ie, mk(2'd2, F_MR2 | F_RW | F_PCW), {tag, "/wb_done"});
          done = 1'b1;
        end else if (w == int'(TO)) begin
          cyc(opc, f3, 1'b0, ir, ie, mk(2'd2, F_MR2 | F_BERR | F_PCW), {tag, "/wb_timeout"});
          done = 1'b1;
        end else begin
          cyc(opc, f3, 1'b0, 1'($urandom), 1'($urandom), mk(2'd2, F_MR2), {tag, "/wb_wait"});
        end
      end
    end else if (opc == C_STORE) begin
      done = 1'b0;
      for (int w = 0; w <= int'(TO) && !done; w++) begin
        if (w == rdy_k) begin
          cyc(opc, f3, 1'b1, ir, ie, mk(2'd1, F_WE2 | F_PCW), {tag, "/st_done"});
          done = 1'b1;
        end else if (w == int'(TO)) begin
          cyc(opc, f3, 1'b0, ir, ie, mk(2'd1, F_BERR | F_PCW), {tag, "/st_timeout"});
          done = 1'b1;
        end else begin
          cyc(opc, f3, 1'b0, 1'($urandom), 1'($urandom), mk(2'd1, F_WE2), {tag, "/st_wait"});
        end
      end
    end else begin
      cyc(opc, f3, 1'($urandom), ir, ie, mk(2'd1, exec_flags(opc, f3)), {tag, "/exec"});
    end
    if (ir && ie) rnd_cyc(mk(2'd3, F_IT | F_PCW), {tag, "/intr"});
  endtask

  initial begin
    logic [6:0] opcs [10];
    logic [6:0] opc;
    int         guard;
    opcs = '{C_OP, C_OP_IMM, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_SYSTEM};

    RESET      = 1'b0;
    OPCODE     = C_STORE;
    FUNC3      = 3'b000;
    INTR       = 1'b1;
    INT_EN     = 1'b1;
    MEM_READY2 = 1'b0;
    #2;
    chk("reset_async", mk(2'd0, F_NONE));
    @(posedge CLK);
    #1;
    chk("reset_held", mk(2'd0, F_NONE));
    RESET = 1'b1;

    run_instr(C_OP, 3'b000, 0, 2, "op_first");
    run_instr(C_OP, 3'b000, 0, 2, "op_second");
    run_instr(C_LOAD, 3'b010, 2, 2, "load_rdy3");
    run_instr(C_STORE, 3'b010, 99, 2, "store_timeout");
    run_instr(C_OP_IMM, 3'b000, 0, 1, "opimm_intr");
    run_instr(C_OP_IMM, 3'b000, 0, 2, "opimm_nointr");
    run_instr(7'b1111111, 3'b000, 0, 2, "illegal");
    run_instr(C_SYSTEM, 3'b000, 0, 2, "mret");
    run_instr(C_SYSTEM, 3'b001, 0, 2, "csrrw");
    run_instr(C_BRANCH, 3'b000, 0, 2, "branch");
    run_instr(C_STORE, 3'b010, int'(TO), 1, "store_rdy_at_limit");
    run_instr(C_LOAD, 3'b010, int'(TO), 2, "load_rdy_at_limit");
    run_instr(C_LOAD, 3'b010, 99, 1, "load_timeout");
    run_instr(C_LOAD, 3'b010, 0, 2, "load_min");

    // Reset pulse during the second WB cycle of a load.
    rnd_cyc(mk(2'd0, F_MR1), "rst_load/fetch");
    cyc(C_LOAD, 3'b000, 1'b0, 1'b1, 1'b1, mk(2'd1, F_MR2), "rst_load/exec");
    cyc(C_LOAD, 3'b000, 1'b0, 1'b1, 1'b1, mk(2'd2, F_MR2), "rst_load/wb1");
    chk("rst_load/wb2_before", mk(2'd2, F_MR2));
    RESET = 1'b0;
    #1;
    chk("rst_load/strobe_drop", mk(2'd0, F_NONE));
    MEM_READY2 = 1'b1;
    #1;
    chk("rst_load/ready_ignored", mk(2'd0, F_NONE));
    @(posedge CLK);
    #1;
    chk("rst_load/held", mk(2'd0, F_NONE));
    RESET = 1'b1;
    run_instr(C_STORE, 3'b000, 99, 2, "post_rst_store_timeout");

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) opc = 7'($urandom);
      else opc = opcs[$urandom_range(0, 9)];
      run_instr(opc, 3'($urandom), int'($urandom_range(0, TO + 2)), 0, $sformatf("rand%0d", n));
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
